// File: rtl/regfile_mp.sv
// Multi-read-port register file with a per-register busy scoreboard and a power-up clear sequence.
// Optional write-to-read forwarding is enabled by defining REGS_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_ce,
    input  logic [NUM_RD*AW-1:0]   i_addr_rd,
    output logic [NUM_RD*XLEN-1:0] o_dat_rd,
    output logic [NUM_RD-1:0]      o_busy_rd,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_addr_wr,
    input  logic [XLEN-1:0]        i_dat_wr,
    input  logic                   i_mark_we,
    input  logic [AW-1:0]          i_mark_addr,
    output logic                   o_ready
);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            cnt_q, cnt_d;
    logic [XLEN-1:0]          regs [DEPTH];
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic                     wr_en, mark_en;
    logic [AW-1:0]            ra;
    logic [NUM_RD*XLEN-1:0]   rd_dat_d, dat_rd_q;
    logic [NUM_RD-1:0]        rd_busy_d, busy_rd_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        wr_en   = (state_q == RUN) && i_ce && i_we && (i_addr_wr != '0);
        mark_en = (state_q == RUN) && i_ce && i_mark_we && (i_mark_addr != '0);
        busy_d  = busy_q;
        // Mark is applied after the write clear so a same-address mark wins.
        if (wr_en)   busy_d[i_addr_wr]   = 1'b0;
        if (mark_en) busy_d[i_mark_addr] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    // Storage is zeroed only by the clear sequence, never by reset itself.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state_q == CLEAR) regs[cnt_q] <= '0;
            else if (wr_en)       regs[i_addr_wr] <= i_dat_wr;
        end
    end

    always_comb begin
        rd_dat_d  = '0;
        rd_busy_d = '0;
        ra        = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra = i_addr_rd[k*AW +: AW];
            rd_dat_d[k*XLEN +: XLEN] = (ra == '0) ? '0 : regs[ra];
            rd_busy_d[k]             = busy_q[ra];
`ifdef REGS_BYPASS_EN
            if (wr_en && (ra == i_addr_wr)) begin
                rd_dat_d[k*XLEN +: XLEN] = i_dat_wr;
                rd_busy_d[k]             = busy_d[ra];
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || state_q != RUN) begin
            dat_rd_q  <= '0;
            busy_rd_q <= '0;
        end else begin
            dat_rd_q  <= rd_dat_d;
            busy_rd_q <= rd_busy_d;
        end
    end

    assign o_dat_rd  = dat_rd_q;
    assign o_busy_rd = busy_rd_q;
    assign o_ready   = (state_q == RUN);

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: array/counter model compared every cycle plus literal checks.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = $clog2(DEPTH);

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic                   i_ce;
    logic [NUM_RD*AW-1:0]   i_addr_rd;
    logic [NUM_RD*XLEN-1:0] o_dat_rd;
    logic [NUM_RD-1:0]      o_busy_rd;
    logic                   i_we;
    logic [AW-1:0]          i_addr_wr;
    logic [XLEN-1:0]        i_dat_wr;
    logic                   i_mark_we;
    logic [AW-1:0]          i_mark_addr;
    logic                   o_ready;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ce        (i_ce),
        .i_addr_rd   (i_addr_rd),
        .o_dat_rd    (o_dat_rd),
        .o_busy_rd   (o_busy_rd),
        .i_we        (i_we),
        .i_addr_wr   (i_addr_wr),
        .i_dat_wr    (i_dat_wr),
        .i_mark_we   (i_mark_we),
        .i_mark_addr (i_mark_addr),
        .o_ready     (o_ready)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural model: contents are zero once running, ready after DEPTH released cycles.
    logic [XLEN-1:0]        m_regs [DEPTH];
    logic [DEPTH-1:0]       m_busy = '0;
    int                     run_cnt = 0;
    logic [NUM_RD*XLEN-1:0] exp_dat = '0;
    logic [NUM_RD-1:0]      exp_busy = '0;
    logic                   check_en = 1'b0;

    always @(posedge i_clk) begin
        logic            wq, mq;
        logic [DEPTH-1:0] nb;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;
        if (i_rst) begin
            run_cnt  <= 0;
            m_busy   <= '0;
            exp_dat  <= '0;
            exp_busy <= '0;
            for (int i = 0; i < DEPTH; i++) m_regs[i] <= '0;
        end else if (run_cnt < DEPTH) begin
            run_cnt  <= run_cnt + 1;
            exp_dat  <= '0;
            exp_busy <= '0;
        end else begin
            wq = i_ce && i_we && (i_addr_wr != 0);
            mq = i_ce && i_mark_we && (i_mark_addr != 0);
            nb = m_busy;
            if (wq) nb[i_addr_wr] = 1'b0;
            if (mq) nb[i_mark_addr] = 1'b1;
            for (int k = 0; k < NUM_RD; k++) begin
                a = i_addr_rd[k*AW +: AW];
                d = (a == 0) ? '0 : m_regs[a];
                b = m_busy[a];
`ifdef REGS_BYPASS_EN
                if (wq && a == i_addr_wr) begin
                    d = i_dat_wr;
                    b = nb[a];
                end
`endif
                exp_dat[k*XLEN +: XLEN] <= d;
                exp_busy[k]             <= b;
            end
            if (wq) m_regs[i_addr_wr] <= i_dat_wr;
            m_busy <= nb;
        end
    end

    always @(negedge i_clk) begin
        if (check_en) begin
            checks++;
            if (o_ready !== (run_cnt >= DEPTH)) begin
                errors++;
                $display("FAIL model_ready t=%0t got %b want %b", $time, o_ready, run_cnt >= DEPTH);
            end
            for (int k = 0; k < NUM_RD; k++) begin
                checks++;
                if (o_dat_rd[k*XLEN +: XLEN] !== exp_dat[k*XLEN +: XLEN]) begin
                    errors++;
                    $display("FAIL model_dat lane%0d t=%0t got %h want %h", k, $time,
                             o_dat_rd[k*XLEN +: XLEN], exp_dat[k*XLEN +: XLEN]);
                end
                checks++;
                if (o_busy_rd[k] !== exp_busy[k]) begin
                    errors++;
                    $display("FAIL model_busy lane%0d t=%0t got %b want %b", k, $time,
                             o_busy_rd[k], exp_busy[k]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic rd(input int a0, input int a1);
        i_addr_rd = {AW'(a1), AW'(a0)};
    endtask

    task automatic wait_ready(input string name);
        for (int i = 1; i < DEPTH; i++) begin
            step();
            chk({name, "_low"}, {63'd0, o_ready}, 64'd0);
        end
        step();
        chk({name, "_high"}, {63'd0, o_ready}, 64'd1);
    endtask

    initial begin
        i_rst = 1'b1; i_ce = 1'b1; i_we = 1'b0; i_addr_wr = '0; i_dat_wr = '0;
        i_mark_we = 1'b0; i_mark_addr = '0; i_addr_rd = '0;
        @(posedge i_clk);
        check_en = 1'b1;
        repeat (2) step();
        chk("reset_ready", {63'd0, o_ready}, 64'd0);
        chk("reset_dat", 64'(o_dat_rd), 64'd0);
        chk("reset_busy", {62'd0, o_busy_rd}, 64'd0);

        i_rst = 1'b0;
        wait_ready("ready1");

        for (int a = 0; a < DEPTH; a++) begin
            rd(a, DEPTH - 1 - a);
            step();
        end
        step();
        chk("clear_read", 64'(o_dat_rd), 64'd0);

        i_we = 1'b1; i_addr_wr = 5; i_dat_wr = 32'hDEADBEEF;
        step();
        i_we = 1'b0; rd(5, 5);
        step();
        chk("x5_both", 64'(o_dat_rd), 64'hDEADBEEF_DEADBEEF);
        chk("x5_busy", {62'd0, o_busy_rd}, 64'd0);

        i_we = 1'b1; i_addr_wr = 0; i_dat_wr = 32'h1234;
        step();
        i_we = 1'b0; rd(0, 5);
        step();
        chk("x0_zero", 64'(o_dat_rd), 64'hDEADBEEF_00000000);

        i_mark_we = 1'b1; i_mark_addr = 7;
        step();
        i_mark_we = 1'b0; rd(7, 7);
        step();
        chk("x7_marked", {62'd0, o_busy_rd}, 64'd3);
        i_we = 1'b1; i_addr_wr = 7; i_dat_wr = 32'h55;
        step();
`ifdef REGS_BYPASS_EN
        chk("x7_fwd_dat", 64'(o_dat_rd), 64'h00000055_00000055);
        chk("x7_fwd_busy", {62'd0, o_busy_rd}, 64'd0);
`else
        chk("x7_old_dat", 64'(o_dat_rd), 64'd0);
        chk("x7_old_busy", {62'd0, o_busy_rd}, 64'd3);
`endif
        i_we = 1'b0;
        step();
        chk("x7_after_dat", 64'(o_dat_rd), 64'h00000055_00000055);
        chk("x7_after_busy", {62'd0, o_busy_rd}, 64'd0);

        i_we = 1'b1; i_addr_wr = 9; i_dat_wr = 32'h99;
        i_mark_we = 1'b1; i_mark_addr = 9; rd(9, 9);
        step();
        i_we = 1'b0; i_mark_we = 1'b0;
        step();
        chk("x9_mark_wins", {62'd0, o_busy_rd}, 64'd3);
        chk("x9_dat", 64'(o_dat_rd), 64'h00000099_00000099);
        i_ce = 1'b0; i_we = 1'b1; i_dat_wr = 32'h77;
        i_mark_we = 1'b1; i_mark_addr = 11;
        step();
        i_we = 1'b0; i_mark_we = 1'b0; rd(9, 11);
        step();
        chk("ce0_dat", 64'(o_dat_rd[XLEN-1:0]), 64'h99);
        chk("ce0_busy", {62'd0, o_busy_rd}, 64'd1);
        i_ce = 1'b1; i_mark_we = 1'b1; i_mark_addr = 0; rd(0, 0);
        step();
        i_mark_we = 1'b0;
        step();
        chk("x0_never_busy", {62'd0, o_busy_rd}, 64'd0);

        for (int a = 1; a < DEPTH; a++) begin
            i_we = 1'b1; i_addr_wr = AW'(a); i_dat_wr = 32'h01010101 * a ^ 32'hC0DE0000;
            i_mark_we = (a % 3 == 0); i_mark_addr = AW'(DEPTH - a);
            rd(a, DEPTH - a);
            step();
        end
        i_we = 1'b0; i_mark_we = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            rd(a, (a * 7) % DEPTH);
            step();
        end

        i_we = 1'b1; i_addr_wr = 3; i_dat_wr = 32'hA5A5A5A5;
        i_mark_we = 1'b1; i_mark_addr = 12;
        step();
        i_we = 1'b0; i_mark_we = 1'b0; rd(3, 12);
        step();
        chk("x3_written", 64'(o_dat_rd[XLEN-1:0]), 64'hA5A5A5A5);
        chk("x12_busy", {62'd0, o_busy_rd}, 64'd2);

        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        repeat (10) step();
        i_rst = 1'b1;
        step();
        chk("midclear_rst_ready", {63'd0, o_ready}, 64'd0);
        i_rst = 1'b0;
        wait_ready("ready2");
        rd(3, 12);
        step();
        chk("x3_cleared", 64'(o_dat_rd), 64'd0);
        chk("busy_cleared", {62'd0, o_busy_rd}, 64'd0);
        for (int a = 0; a < DEPTH; a++) begin
            rd(a, a);
            step();
        end
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers, power of two, at least 2; AW = clog2(DEPTH).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports, 1..4.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_ce, input, 1 bit: clock enable for write and mark operations.
REQ-007 SHALL have port i_addr_rd, input, NUM_RD*AW bits: packed read addresses; port k occupies bits [k*AW +: AW].
REQ-008 SHALL have port o_dat_rd, output, NUM_RD*XLEN bits: packed registered read data.
REQ-009 SHALL have port o_busy_rd, output, NUM_RD bits: registered scoreboard busy flag per read port.
REQ-010 SHALL have ports i_we (input, 1), i_addr_wr (input, AW) and i_dat_wr (input, XLEN): the write port.
REQ-011 SHALL have ports i_mark_we (input, 1) and i_mark_addr (input, AW): the scoreboard set-pending port.
REQ-012 SHALL have port o_ready, output, 1 bit: high when the clear sequence is done and the block is operational.

Function
REQ-013 SHALL contain a two-state FSM: CLEAR and RUN.
REQ-014 In CLEAR, the block SHALL write zero to register[cnt] each cycle and increment cnt, where cnt is AW bits wide.
REQ-015 When cnt equals DEPTH-1 in CLEAR, the FSM SHALL move to RUN on the next edge; o_ready SHALL rise exactly DEPTH cycles after i_rst deasserts.
REQ-016 In CLEAR, the block SHALL ignore i_we and i_mark_we, drive every o_dat_rd lane to 0, and drive o_busy_rd to 0.
REQ-017 In RUN, when i_ce, i_we and i_addr_wr != 0 are all true, register[i_addr_wr] SHALL be loaded with i_dat_wr.
REQ-018 Register 0 SHALL always read 0 and SHALL never be written or marked busy.
REQ-019 Each read port SHALL have 1-cycle latency: the data for address k sampled at edge N appears on o_dat_rd from edge N onward. Reads update regardless of i_ce.
REQ-020 The scoreboard SHALL hold one busy bit per register.
REQ-021 In RUN, when i_ce, i_mark_we and i_mark_addr != 0 are all true, busy[i_mark_addr] SHALL be set.
REQ-022 A qualifying write per REQ-017 SHALL clear busy[i_addr_wr].
REQ-023 When a mark and a write target the same address in the same cycle, the mark SHALL win and the bit ends set.
REQ-024 o_busy_rd[k] SHALL be registered with the same latency and address as o_dat_rd lane k.
REQ-025 Simultaneous reads of the same address on several ports SHALL return identical data and busy values.

Reset
REQ-026 While i_rst is high, the block SHALL set FSM=CLEAR, cnt=0, o_ready=0, all o_dat_rd=0, all o_busy_rd=0 and every busy bit to 0.
REQ-027 i_rst asserted mid-CLEAR or mid-RUN SHALL restart the clear sequence from cnt=0; register contents are zeroed only by the sequence, not by the reset itself.

Configuration
REQ-028 Macro REGS_BYPASS_EN SHALL control write-to-read forwarding.
REQ-029 When REGS_BYPASS_EN is defined, a read port whose address equals a same-cycle qualifying write address SHALL capture i_dat_wr, and its busy flag SHALL capture the post-update value (0, or 1 if a same-address mark occurs per REQ-023).
REQ-030 When REGS_BYPASS_EN is undefined, such a read SHALL capture the old register contents and the pre-update busy bit.
REQ-031 The macro SHALL NOT affect the clear sequence or register 0.

Verification
REQ-032 DEPTH=32: deassert i_rst -> o_ready=0 for 32 cycles, then 1; every address reads 0.
REQ-033 In RUN, write 0xDEADBEEF to x5, then read x5 on both ports the next cycle -> both lanes return 0xDEADBEEF and busy 0; write 0x1234 to x0 -> x0 still reads 0.
REQ-034 Mark x7, then read x7 -> busy=1; write 0x55 to x7 with a same-cycle read of x7 -> with REGS_BYPASS_EN: data 0x55, busy 0; without it: old data, busy 1; on the following read, busy=0 in both builds.
REQ-035 Mark x9 and write x9 in the same cycle -> busy[9]=1 afterwards; i_ce=0 with i_we=1 -> no change.
REQ-036 Write 0xA5A5A5A5 to x3, then pulse i_rst at cnt=10 of a later clear -> cnt restarts, o_ready rises 32 cycles after release, x3 reads 0, all busy bits 0.
